// File: rtl/rival_car_spawner.sv
// Rival car spawner: turns LFSR bytes into lane-legal, gap-paced spawn requests
// offered to the sprite manager over a valid/ready handshake.
module rival_car_spawner #(
    parameter logic [4:0]  INITIAL_DELAY = 5'd8,
    parameter logic [4:0]  MIN_GAP       = 5'd4,
    parameter int unsigned MAX_REJECT    = 15,
    parameter logic [9:0]  LANE0_X       = 10'd200,
    parameter logic [9:0]  LANE_PITCH    = 10'd80
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic [7:0] rand_in,
    output logic       spawn_valid,
    input  logic       spawn_ready,
    output logic [1:0] spawn_lane,
    output logic [9:0] spawn_x,
    output logic [7:0] spawn_count
);

    localparam int REJ_W = (MAX_REJECT < 2) ? 1 : $clog2(MAX_REJECT + 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_GAP = 2'd1,
        SAMPLE   = 2'd2,
        OFFER    = 2'd3
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             has_last;
    logic [1:0]       last_lane;
    logic [4:0]       gap_cnt;
    logic [4:0]       next_gap;
    logic [REJ_W-1:0] rej_cnt;

    logic [1:0] cand;
    logic       reject;
    logic       at_limit;
    logic [1:0] pick_lane;
    logic [4:0] pick_gap;
    logic       take;
    logic       handshake;
    logic       unused_rand;

    assign unused_rand = ^rand_in[3:2];

    function automatic logic [9:0] lane_x(input logic [1:0] lane);
        case (lane)
            2'd0:    lane_x = LANE0_X;
            2'd1:    lane_x = LANE0_X + LANE_PITCH;
            default: lane_x = LANE0_X + LANE_PITCH + LANE_PITCH;
        endcase
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; dropping enable aborts from any state
    always_comb begin
        next_state = state;
        if (!enable) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:     next_state = WAIT_GAP;
                WAIT_GAP: next_state = (gap_cnt == 5'd0) ? SAMPLE : WAIT_GAP;
                SAMPLE:   next_state = take ? OFFER : SAMPLE;
                OFFER:    next_state = handshake ? WAIT_GAP : OFFER;
                default:  next_state = IDLE;
            endcase
        end
    end

    // Sample decode: rejection test, forced lane after too many rejects
    always_comb begin
        cand      = rand_in[1:0];
        reject    = (cand == 2'd3) || (has_last && (cand == last_lane));
        at_limit  = (rej_cnt == REJ_W'(MAX_REJECT));
        pick_lane = 2'd0;
        if (!reject) begin
            pick_lane = cand;
        end else if (has_last) begin
            case (last_lane)
                2'd0:    pick_lane = 2'd1;
                2'd1:    pick_lane = 2'd2;
                default: pick_lane = 2'd0;
            endcase
        end else begin
            pick_lane = 2'd0;
        end
        pick_gap  = MIN_GAP + {1'b0, rand_in[7:4]};
        take      = (state == SAMPLE) && (!reject || at_limit);
        handshake = (state == OFFER) && enable && spawn_valid && spawn_ready;
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            spawn_valid <= 1'b0;
            spawn_lane  <= 2'd0;
            spawn_x     <= 10'd0;
            spawn_count <= 8'd0;
            has_last    <= 1'b0;
            last_lane   <= 2'd0;
            gap_cnt     <= 5'd0;
            next_gap    <= 5'd0;
            rej_cnt     <= '0;
        end else if (!enable) begin
            spawn_valid <= 1'b0;
            rej_cnt     <= '0;
        end else begin
            case (state)
                IDLE: gap_cnt <= INITIAL_DELAY;
                WAIT_GAP: begin
                    if (frame_tick && (gap_cnt != 5'd0)) begin
                        gap_cnt <= gap_cnt - 5'd1;
                    end
                end
                SAMPLE: begin
                    if (take) begin
                        spawn_lane  <= pick_lane;
                        spawn_x     <= lane_x(pick_lane);
                        next_gap    <= pick_gap;
                        rej_cnt     <= '0;
                        spawn_valid <= 1'b1;
                    end else begin
                        rej_cnt <= rej_cnt + REJ_W'(1);
                    end
                end
                OFFER: begin
                    if (handshake) begin
                        last_lane   <= spawn_lane;
                        has_last    <= 1'b1;
                        gap_cnt     <= next_gap;
                        spawn_valid <= 1'b0;
                        if (spawn_count != 8'd255) begin
                            spawn_count <= spawn_count + 8'd1;
                        end
                    end
                end
                default: spawn_valid <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_rival_car_spawner.sv
// Directed bench for rival_car_spawner with hand-computed expectations.
module tb_rival_car_spawner;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       frame_tick;
    logic [7:0] rand_in;
    logic       spawn_valid;
    logic       spawn_ready;
    logic [1:0] spawn_lane;
    logic [9:0] spawn_x;
    logic [7:0] spawn_count;

    int n_cmp = 0;
    int n_bad = 0;

    rival_car_spawner #(.INITIAL_DELAY(5'd2)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .frame_tick  (frame_tick),
        .rand_in     (rand_in),
        .spawn_valid (spawn_valid),
        .spawn_ready (spawn_ready),
        .spawn_lane  (spawn_lane),
        .spawn_x     (spawn_x),
        .spawn_count (spawn_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; frame_tick = 1'b0; rand_in = 8'h51; spawn_ready = 1'b0;
        step(); step();
        n_cmp++;
        if (spawn_valid !== 1'b0 || spawn_count !== 8'd0) begin
            n_bad++; $display("FAIL reset_init: valid=%0b count=%0d, want 0/0", spawn_valid, spawn_count);
        end
        rst = 1'b0; enable = 1'b1;
        step(); tick(2); step(); step();
        n_cmp++;
        if (spawn_valid !== 1'b1) begin
            n_bad++; $display("FAIL reset_reach_offer: valid=%0b want 1", spawn_valid);
        end
        spawn_ready = 1'b1; rst = 1'b1;
        step();
        n_cmp++;
        if (spawn_valid !== 1'b0 || spawn_lane !== 2'd0 || spawn_x !== 10'd0 || spawn_count !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_mid_offer: valid=%0b lane=%0d x=%0d count=%0d, want all 0",
                     spawn_valid, spawn_lane, spawn_x, spawn_count);
        end
        rst = 1'b0; spawn_ready = 1'b0; enable = 1'b0;
        step();
    endtask

    task automatic test_first_spawn();
        enable = 1'b1; rand_in = 8'h51;
        step(); tick(2); step();
        n_cmp++;
        if (spawn_valid !== 1'b0) begin
            n_bad++; $display("FAIL first_early: valid=%0b want 0", spawn_valid);
        end
        step();
        n_cmp++;
        if (spawn_valid !== 1'b1 || spawn_lane !== 2'd1 || spawn_x !== 10'd280) begin
            n_bad++; $display("FAIL first_offer: valid=%0b lane=%0d x=%0d, want 1/1/280",
                              spawn_valid, spawn_lane, spawn_x);
        end
        spawn_ready = 1'b1;
        step();
        spawn_ready = 1'b0;
        n_cmp++;
        if (spawn_valid !== 1'b0 || spawn_count !== 8'd1) begin
            n_bad++; $display("FAIL first_handshake: valid=%0b count=%0d, want 0/1", spawn_valid, spawn_count);
        end
    endtask

    task automatic test_rejection();
        rand_in = 8'h00;
        tick(8); step(); step();
        n_cmp++;
        if (spawn_valid !== 1'b0) begin
            n_bad++; $display("FAIL gap9_early: valid=%0b want 0 after 8 ticks", spawn_valid);
        end
        tick(1); step();
        rand_in = 8'h03; step();
        n_cmp++;
        if (spawn_valid !== 1'b0) begin
            n_bad++; $display("FAIL reject_lane3: valid=%0b want 0", spawn_valid);
        end
        rand_in = 8'h21; step();
        n_cmp++;
        if (spawn_valid !== 1'b0) begin
            n_bad++; $display("FAIL reject_repeat: valid=%0b want 0", spawn_valid);
        end
        rand_in = 8'h92; step();
        n_cmp++;
        if (spawn_valid !== 1'b1 || spawn_lane !== 2'd2 || spawn_x !== 10'd360) begin
            n_bad++; $display("FAIL reject_accept: valid=%0b lane=%0d x=%0d, want 1/2/360",
                              spawn_valid, spawn_lane, spawn_x);
        end
    endtask

    task automatic test_backpressure();
        spawn_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_in = 8'h13 + 8'(i * 37);
            step();
            n_cmp++;
            if (spawn_valid !== 1'b1 || spawn_lane !== 2'd2 || spawn_x !== 10'd360 || spawn_count !== 8'd1) begin
                n_bad++; $display("FAIL hold_%0d: valid=%0b lane=%0d x=%0d count=%0d, want 1/2/360/1",
                                  i, spawn_valid, spawn_lane, spawn_x, spawn_count);
            end
        end
        spawn_ready = 1'b1;
        step();
        spawn_ready = 1'b0;
        n_cmp++;
        if (spawn_valid !== 1'b0 || spawn_count !== 8'd2) begin
            n_bad++; $display("FAIL hold_release: valid=%0b count=%0d, want 0/2", spawn_valid, spawn_count);
        end
        rand_in = 8'h00;
        tick(12); step(); step();
        n_cmp++;
        if (spawn_valid !== 1'b0) begin
            n_bad++; $display("FAIL gap13_early: valid=%0b want 0 after 12 ticks", spawn_valid);
        end
        tick(1); step(); step();
        n_cmp++;
        if (spawn_valid !== 1'b1 || spawn_lane !== 2'd0 || spawn_x !== 10'd200) begin
            n_bad++; $display("FAIL gap13_offer: valid=%0b lane=%0d x=%0d, want 1/0/200",
                              spawn_valid, spawn_lane, spawn_x);
        end
        spawn_ready = 1'b1;
        step();
        spawn_ready = 1'b0;
        n_cmp++;
        if (spawn_count !== 8'd3) begin
            n_bad++; $display("FAIL gap13_count: count=%0d want 3", spawn_count);
        end
    endtask

    task automatic test_forced_lane();
        rand_in = 8'hFF;
        tick(4); step();
        for (int i = 0; i < 15; i++) step();
        n_cmp++;
        if (spawn_valid !== 1'b0) begin
            n_bad++; $display("FAIL forced_early: valid=%0b want 0 after 15 samples", spawn_valid);
        end
        step();
        n_cmp++;
        if (spawn_valid !== 1'b1 || spawn_lane !== 2'd1 || spawn_x !== 10'd280) begin
            n_bad++; $display("FAIL forced_offer: valid=%0b lane=%0d x=%0d, want 1/1/280",
                              spawn_valid, spawn_lane, spawn_x);
        end
        spawn_ready = 1'b1;
        step();
        spawn_ready = 1'b0;
        rand_in = 8'h02;
        tick(18); step(); step();
        n_cmp++;
        if (spawn_valid !== 1'b0 || spawn_count !== 8'd4) begin
            n_bad++; $display("FAIL gap19_early: valid=%0b count=%0d, want 0/4", spawn_valid, spawn_count);
        end
        tick(1); step(); step();
        n_cmp++;
        if (spawn_valid !== 1'b1 || spawn_lane !== 2'd2) begin
            n_bad++; $display("FAIL gap19_offer: valid=%0b lane=%0d, want 1/2", spawn_valid, spawn_lane);
        end
    endtask

    task automatic test_abort();
        enable = 1'b0; spawn_ready = 1'b1;
        step();
        n_cmp++;
        if (spawn_valid !== 1'b0 || spawn_count !== 8'd4) begin
            n_bad++; $display("FAIL abort_handshake: valid=%0b count=%0d, want 0/4", spawn_valid, spawn_count);
        end
        enable = 1'b1;
        step(); tick(2); step();
        rand_in = 8'h01; step();
        n_cmp++;
        if (spawn_valid !== 1'b0) begin
            n_bad++; $display("FAIL abort_keeps_last: valid=%0b want 0 (lane 1 repeat)", spawn_valid);
        end
        rand_in = 8'h00; step();
        n_cmp++;
        if (spawn_valid !== 1'b1 || spawn_lane !== 2'd0 || spawn_count !== 8'd4) begin
            n_bad++; $display("FAIL abort_restart: valid=%0b lane=%0d count=%0d, want 1/0/4",
                              spawn_valid, spawn_lane, spawn_count);
        end
        step();
        spawn_ready = 1'b0;
        n_cmp++;
        if (spawn_valid !== 1'b0 || spawn_count !== 8'd5) begin
            n_bad++; $display("FAIL abort_next: valid=%0b count=%0d, want 0/5", spawn_valid, spawn_count);
        end
    endtask

    task automatic test_saturation();
        int b;
        int want;
        logic tog;
        tog = 1'b0;
        for (int n = 0; n < 260; n++) begin
            b = 0;
            frame_tick = 1'b1;
            while (!spawn_valid && b < 60) begin
                rand_in = {7'd0, tog};
                tog = ~tog;
                step();
                b++;
            end
            frame_tick = 1'b0;
            if (b >= 60) begin
                n_cmp++; n_bad++;
                $display("FAIL sat_timeout: no spawn_valid in spawn %0d, want valid within 60 cycles", n);
                break;
            end
            spawn_ready = 1'b1;
            step();
            spawn_ready = 1'b0;
            want = (5 + n + 1 > 255) ? 255 : 5 + n + 1;
            if (n >= 248) begin
                n_cmp++;
                if (spawn_count !== 8'(want)) begin
                    n_bad++; $display("FAIL sat_count_%0d: count=%0d want %0d", n, spawn_count, want);
                end
            end
        end
        n_cmp++;
        if (spawn_count !== 8'd255) begin
            n_bad++; $display("FAIL sat_final: count=%0d want 255", spawn_count);
        end
    endtask

    initial begin
        test_reset();
        test_first_spawn();
        test_rejection();
        test_backpressure();
        test_forced_lane();
        test_abort();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/rival_car_spawner.md
# rival_car_spawner

Consumer of the 8-bit pseudo-random stream in the road-fighter game. Each frame it decides when and in which lane the next rival car appears. It turns raw LFSR bytes into bounded, game-legal spawn requests using rejection sampling, a randomised inter-spawn gap and a valid/ready handshake. It sits between the LFSR and the obstacle/sprite manager, which accepts one spawn per handshake.

## Interface
Parameters:
- `INITIAL_DELAY`, default 8: frames between enable rising and the first sample (1..31).
- `MIN_GAP`, default 4: minimum frames between spawns; gap = `MIN_GAP` + `rand_in[7:4]`, legal range 1..16.
- `MAX_REJECT`, default 15: consecutive rejected samples before the lane is forced.
- `LANE0_X`, default 10'd200: x pixel of lane 0.
- `LANE_PITCH`, default 10'd80: x spacing between lanes.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `enable`  in  1  game running; low aborts activity.
- `frame_tick`  in  1  one-cycle pulse per video frame.
- `rand_in`  in  8  LFSR output; advances every clk.
- `spawn_valid`  out  1  spawn request pending.
- `spawn_ready`  in  1  sprite manager accepts the request.
- `spawn_lane`  out  2  lane 0..2; never 3.
- `spawn_x`  out  10  `LANE0_X` + `spawn_lane`*`LANE_PITCH`.
- `spawn_count`  out  8  accepted spawns since reset; saturates at 255.

## Operation
- States: IDLE, WAIT_GAP, SAMPLE, OFFER.
- IDLE:
  - outputs idle.
  - On `enable`=1, load `gap_cnt` ← `INITIAL_DELAY` and move to WAIT_GAP.
- WAIT_GAP:
  - Each `frame_tick` decrements `gap_cnt`.
  - When `gap_cnt` reaches 0, move to SAMPLE on the next edge.
  - Ticks are ignored in all other states.
- SAMPLE: evaluate `rand_in` every clk.
  - Candidate lane = `rand_in[1:0]`.
  - Reject the candidate if it is 3, or if `has_last`=1 and it equals `last_lane`.
  - On reject, increment `rej_cnt`.
  - On accept:
    - latch the lane and `next_gap` = `MIN_GAP` + `rand_in[7:4]` (5-bit, no overflow within the legal range);
    - clear `rej_cnt`;
    - go to OFFER and assert `spawn_valid` on the same edge.
  - If `rej_cnt` = `MAX_REJECT` and the current sample would also be rejected:
    - accept lane = (`last_lane`+1) mod 3, or lane 0 if `has_last`=0;
    - take the gap from the current `rand_in[7:4]`.
- OFFER:
  - `spawn_valid`, `spawn_lane` and `spawn_x` stay stable until `spawn_valid`&&`spawn_ready` at a clock edge.
  - On the handshake:
    - `last_lane` ← lane, `has_last` ← 1;
    - `spawn_count` increments, saturating at 255;
    - `gap_cnt` ← `next_gap`;
    - `spawn_valid` ← 0;
    - move to WAIT_GAP.
- `enable`=0 in any state:
  - next state IDLE, `spawn_valid` ← 0;
  - no handshake is counted;
  - `rej_cnt` is cleared;
  - `last_lane` and `has_last` are retained.
- `spawn_x` is registered together with `spawn_lane`; no combinational path from `rand_in` to outputs.

## Timing
- Reset values:
  - state IDLE;
  - `spawn_valid`=0, `spawn_lane`=0, `spawn_x`=0, `spawn_count`=0;
  - `has_last`=0, `last_lane`=0, `gap_cnt`=0, `rej_cnt`=0.
- `rst` overrides `enable`, `frame_tick` and handshake in the same cycle.
- Enable to WAIT_GAP: 1 cycle.
- SAMPLE entry: the edge after the tick that zeroes `gap_cnt`.
- Accepted sample to `spawn_valid`=1: visible the cycle after the sampling edge; best case 1 cycle after SAMPLE entry.
- Worst case SAMPLE duration: `MAX_REJECT`+1 cycles.
- Handshake to `spawn_valid`=0: next cycle. Back-to-back spawns are impossible because the gap is ≥1 frame.
- `spawn_ready` high outside OFFER has no effect.
- `enable` falling in the same cycle as a handshake: abort wins, and the spawn is not counted.
- A `frame_tick` coinciding with the WAIT_GAP entry edge is not counted.

## Test plan
- Reset: assert `rst` mid-OFFER with `spawn_ready`=1 → next cycle all outputs 0 and state IDLE; `spawn_count` stays 0.
- First spawn:
  - `INITIAL_DELAY`=2, `enable`=1, two `frame_tick` pulses, `rand_in`=8'h51;
  - → `spawn_valid`=1 two cycles after the second tick, `spawn_lane`=1, `spawn_x`=280;
  - after the handshake, next gap = 9 frames.
- Rejection:
  - `last_lane`=1, `rand_in` sequence 8'h03, 8'h21, 8'h92;
  - → first two samples rejected; lane 2 accepted on the third; `spawn_x`=360; gap = 13.
- Backpressure:
  - hold `spawn_ready`=0 for 5 cycles in OFFER → valid, lane and x are stable and `spawn_count` is unchanged;
  - raise `spawn_ready` → `spawn_count` +1, `spawn_valid`=0 next cycle.
- Forced lane: `last_lane`=0, `rand_in`=8'hFF held → exactly 16 SAMPLE cycles, then `spawn_lane`=1 with gap = 19.
- Abort and saturation:
  - drop `enable` in OFFER → `spawn_valid`=0 next cycle, `spawn_count` unchanged, IDLE;
  - run 260 handshakes → `spawn_count`=255.
